clock_display_seq: RTL and testbench

Parametrised successor to the four-digit clock sequencer. Keeps HH:MM(:SS) time from a Tick timebase and accepts set-time pulses. Time-multiplexes BCD digits onto a shared D bus with one-hot digit enables and a decimal point. Adds a selectable digit count (4 = HHMM, 6 = HHMMSS), 12/24-hour mode with leading-zero blanking, a blinking colon DP, a PM indicator and a programmable scan rate.

---
 rtl/clock_seq_pkg.sv | 43 ++++
 rtl/bcd2_counter.sv | 45 ++++
 rtl/clock_display_seq.sv | 145 ++++++++++++++
 tb/tb_clock_display_seq.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_seq_pkg.sv
// rtl/clock_seq_pkg.sv - shared BCD types, display slot indices and 12-hour conversion
package clock_seq_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t units;
    } bcd2_t;

    typedef struct packed {
        bcd2_t hour;
        logic  pm;
    } hour12_t;

    localparam logic [2:0] SLOT_HT = 3'd0;
    localparam logic [2:0] SLOT_HU = 3'd1;
    localparam logic [2:0] SLOT_MT = 3'd2;
    localparam logic [2:0] SLOT_MU = 3'd3;
    localparam logic [2:0] SLOT_ST = 3'd4;
    localparam logic [2:0] SLOT_SU = 3'd5;

    localparam int HOUR_PM_THRESHOLD = 12;

    // 00 reads as 12, 13..23 fold down by twelve, 01..12 pass through.
    function automatic hour12_t to_12h(input bcd2_t h);
        hour12_t    r;
        logic [4:0] bin;
        logic [4:0] disp;
        bin  = 5'(h.tens) * 5'd10 + 5'(h.units);
        r.pm = (bin >= 5'(HOUR_PM_THRESHOLD));
        if (bin == 5'd0)
            disp = 5'(HOUR_PM_THRESHOLD);
        else if (bin > 5'(HOUR_PM_THRESHOLD))
            disp = bin - 5'(HOUR_PM_THRESHOLD);
        else
            disp = bin;
        r.hour.tens  = (disp >= 5'd10) ? 4'd1 : 4'd0;
        r.hour.units = (disp >= 5'd10) ? 4'(disp - 5'd10) : 4'(disp);
        return r;
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit BCD counter wrapping at MODULUS-1 with carry out
module bcd2_counter
    import clock_seq_pkg::*;
#(
    parameter int MODULUS = 60
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inc,
    input  logic  clr,
    output bcd2_t value,
    output logic  carry
);

    localparam bcd_t LAST_TENS  = bcd_t'((MODULUS - 1) / 10);
    localparam bcd_t LAST_UNITS = bcd_t'((MODULUS - 1) % 10);

    if (MODULUS != 60 && MODULUS != 24) begin : g_bad_modulus
        $error("bcd2_counter MODULUS must be 60 or 24");
    end

    logic at_last;

    assign at_last = (value.tens == LAST_TENS) && (value.units == LAST_UNITS);
    // Clear wins over increment, so a cleared counter never reports a wrap.
    assign carry   = inc && !clr && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            if (at_last) begin
                value <= '0;
            end else if (value.units == 4'd9) begin
                value.tens  <= value.tens + 4'd1;
                value.units <= 4'd0;
            end else begin
                value.units <= value.units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock_display_seq.sv
// rtl/clock_display_seq.sv - BCD time-of-day keeper with multiplexed 4/6 digit display scan
module clock_display_seq
    import clock_seq_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int TICKS_PER_SEC = 256,
    parameter int SCAN_DIV      = 16
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  Tick,
    input  logic                  SyncMinIn,
    input  logic                  SyncHourIn,
    input  logic                  Mode24,
    output logic [3:0]            D,
    output logic [NUM_DIGITS-1:0] Digit,
    output logic                  DP
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICKS_PER_SEC / 2);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

    if (NUM_DIGITS != 4 && NUM_DIGITS != 6) begin : g_bad_digits
        $error("NUM_DIGITS must be 4 or 6");
    end
    if (TICKS_PER_SEC < 2) begin : g_bad_ticks
        $error("TICKS_PER_SEC must be at least 2");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan
        $error("SCAN_DIV must be at least 1");
    end

    logic [PW-1:0] presc;
    logic          sec_tick;
    logic          sec_inc;
    logic          min_inc;
    logic          hour_inc;
    logic          sec_wrap;
    logic          min_wrap;
    logic          hour_wrap_unused;
    bcd2_t         sec;
    bcd2_t         min;
    bcd2_t         hour;

    assign sec_tick = Tick && (presc == PRESC_LAST);
    // A minute set restarts the second, so it masks the natural second carry.
    assign sec_inc  = sec_tick && !SyncMinIn;
    assign min_inc  = SyncMinIn || sec_wrap;
    // Set-minute wraps never reach the hour; a natural carry merges with an hour set.
    assign hour_inc = SyncHourIn || (min_wrap && !SyncMinIn);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            presc <= '0;
        end else if (SyncMinIn) begin
            presc <= '0;
        end else if (Tick) begin
            presc <= sec_tick ? '0 : presc + PW'(1);
        end
    end

    bcd2_counter #(.MODULUS(60)) u_sec (
        .clk   (Clock),
        .rst_n (nReset),
        .inc   (sec_inc),
        .clr   (SyncMinIn),
        .value (sec),
        .carry (sec_wrap)
    );

    bcd2_counter #(.MODULUS(60)) u_min (
        .clk   (Clock),
        .rst_n (nReset),
        .inc   (min_inc),
        .clr   (1'b0),
        .value (min),
        .carry (min_wrap)
    );

    bcd2_counter #(.MODULUS(24)) u_hour (
        .clk   (Clock),
        .rst_n (nReset),
        .inc   (hour_inc),
        .clr   (1'b0),
        .value (hour),
        .carry (hour_wrap_unused)
    );

    logic [SW-1:0]         scan_cnt;
    logic [2:0]            idx;
    hour12_t               h12;
    bcd2_t                 hour_disp;
    bcd_t                  slot_val;
    logic                  slot_dp;
    logic                  blank;
    logic [NUM_DIGITS-1:0] digit_sel;

    assign h12       = to_12h(hour);
    assign hour_disp = Mode24 ? hour : h12.hour;
    assign blank     = !Mode24 && (idx == SLOT_HT) && (hour_disp.tens == 4'd0);
    assign digit_sel = NUM_DIGITS'(1) << (IDX_LAST - idx);

    always_comb begin
        slot_val = '0;
        slot_dp  = 1'b0;
        case (idx)
            SLOT_HT: slot_val = hour_disp.tens;
            SLOT_HU: slot_val = hour_disp.units;
            SLOT_MT: slot_val = min.tens;
            SLOT_MU: slot_val = min.units;
            SLOT_ST: slot_val = sec.tens;
            SLOT_SU: slot_val = sec.units;
            default: slot_val = '0;
        endcase
        // Colon blinks in the first half of each second; PM dot sits on the rightmost digit.
        if (idx == SLOT_HU)
            slot_dp = (presc < PRESC_HALF);
        else if (idx == IDX_LAST)
            slot_dp = !Mode24 && h12.pm;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            scan_cnt <= '0;
            idx      <= SLOT_HT;
            D        <= '0;
            Digit    <= '0;
            DP       <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? SLOT_HT : idx + 3'd1;
            D        <= blank ? '0 : slot_val;
            Digit    <= blank ? '0 : digit_sel;
            DP       <= blank ? 1'b0 : slot_dp;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_clock_display_seq.sv
// tb/tb_clock_display_seq.sv - randomized and directed checks of clock_display_seq against a seconds-of-day model
module tb_clock_display_seq;

    localparam int ND  = 6;
    localparam int TPS = 4;
    localparam int SD  = 2;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic tick   = 1'b0;
    logic minp   = 1'b0;
    logic hourp  = 1'b0;
    logic mode24 = 1'b1;
    logic zero   = 1'b0;
    logic one    = 1'b1;

    logic [3:0]    d;
    logic [ND-1:0] digit;
    logic          dp;
    logic [3:0]    d4;
    logic [3:0]    digit4;
    logic          dp4;

    int checks = 0;
    int errors = 0;

    clock_display_seq #(.NUM_DIGITS(ND), .TICKS_PER_SEC(TPS), .SCAN_DIV(SD)) dut (
        .Clock(clk), .nReset(rst_n), .Tick(tick), .SyncMinIn(minp),
        .SyncHourIn(hourp), .Mode24(mode24), .D(d), .Digit(digit), .DP(dp)
    );

    clock_display_seq #(.NUM_DIGITS(4), .TICKS_PER_SEC(TPS), .SCAN_DIV(SD)) dut4 (
        .Clock(clk), .nReset(rst_n), .Tick(zero), .SyncMinIn(zero),
        .SyncHourIn(zero), .Mode24(one), .D(d4), .Digit(digit4), .DP(dp4)
    );

    always #5 clk = ~clk;

    // Reference: time as seconds of day, prescaler as an integer, scan position from cycle count.
    int            m_t;
    int            m_p;
    int            m_n;
    logic [3:0]    e_d;
    logic [ND-1:0] e_dig;
    logic          e_dp;

    function automatic logic [ND+4:0] exp_slot(int slot, int t, int p, logic mode);
        int            h;
        int            hd;
        int            vals[6];
        logic [3:0]    dv;
        logic [ND-1:0] dg;
        logic          dpv;
        h       = t / 3600;
        hd      = mode ? h : ((h == 0) ? 12 : ((h > 12) ? h - 12 : h));
        vals[0] = hd / 10;
        vals[1] = hd % 10;
        vals[2] = ((t / 60) % 60) / 10;
        vals[3] = ((t / 60) % 60) % 10;
        vals[4] = (t % 60) / 10;
        vals[5] = (t % 60) % 10;
        dv      = 4'(vals[slot]);
        dg      = ND'(1) << (ND - 1 - slot);
        if (slot == 1)
            dpv = (p < TPS / 2);
        else if (slot == ND - 1)
            dpv = !mode && (h >= 12);
        else
            dpv = 1'b0;
        if (!mode && slot == 0 && hd < 10) begin
            dv  = '0;
            dg  = '0;
            dpv = 1'b0;
        end
        return {dv, dg, dpv};
    endfunction

    function automatic int next_t(int t, int p, logic tk, logic mn, logic hr);
        int h;
        int n;
        h = t / 3600;
        if (mn)
            n = h * 3600 + ((((t / 60) % 60) + 1) % 60) * 60;
        else if (tk && p == TPS - 1)
            n = (t + 1) % 86400;
        else
            n = t;
        if (hr)
            n = ((h + 1) % 24) * 3600 + n % 3600;
        return n;
    endfunction

    function automatic int next_p(int p, logic tk, logic mn);
        if (mn) return 0;
        if (tk) return (p + 1) % TPS;
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t   <= 0;
            m_p   <= 0;
            m_n   <= 0;
            e_d   <= '0;
            e_dig <= '0;
            e_dp  <= 1'b0;
        end else begin
            if (m_n % SD == SD - 1)
                {e_d, e_dig, e_dp} <= exp_slot((m_n / SD) % ND, m_t, m_p, mode24);
            m_t <= next_t(m_t, m_p, tick, minp, hourp);
            m_p <= next_p(m_p, tick, minp);
            m_n <= m_n + 1;
        end
    end

    task automatic step(input logic tk, input logic mn, input logic hr);
        tick  = tk;
        minp  = mn;
        hourp = hr;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        tick  = 1'b0;
        minp  = 1'b0;
        hourp = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_time(input int hh, input int mm, input int ticks);
        for (int i = 0; i < hh; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < mm; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < ticks; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    // Slot 0 lands in the top nibble / top bit so values read as HHMMSS.
    task automatic capture_frame(output logic [23:0] vals, output logic [5:0] dps, output logic [5:0] seen);
        vals = '0;
        dps  = '0;
        seen = '0;
        repeat (2 * ND * SD + 2) begin
            step(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < ND; i++) begin
                if (digit[ND-1-i]) begin
                    vals[(ND-1-i)*4 +: 4] = d;
                    dps[ND-1-i]           = dp;
                    seen[ND-1-i]          = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [5:0] exp6;
        logic [3:0] exp4;
        logic [5:0] base6;
        logic [3:0] base4;
        base6 = 6'b100000;
        base4 = 4'b1000;
        mode24 = 1'b1;
        reset_dut();
        checks++;
        if ({d, digit, dp} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs act=%h exp=0", {d, digit, dp});
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (digit !== 6'd0 || digit4 !== 4'd0) begin
            errors++;
            $display("FAIL reset_first_cycle digit=%b digit4=%b exp=0", digit, digit4);
        end
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            exp6 = base6 >> (k % 6);
            exp4 = base4 >> (k % 4);
            checks++;
            if (digit !== exp6 || d !== 4'd0) begin
                errors++;
                $display("FAIL reset_scan6 k=%0d digit=%b d=%0d exp_digit=%b exp_d=0", k, digit, d, exp6);
            end
            checks++;
            if (digit4 !== exp4 || d4 !== 4'd0 || dp4 !== (k % 4 == 1)) begin
                errors++;
                $display("FAIL reset_scan4 k=%0d digit4=%b dp4=%b exp_digit4=%b", k, digit4, dp4, exp4);
            end
        end
    endtask

    task automatic test_timekeeping();
        logic [23:0] vals;
        logic [5:0]  dps;
        logic [5:0]  seen;
        mode24 = 1'b1;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if ({d, digit, dp} !== {e_d, e_dig, e_dp}) begin
                errors++;
                $display("FAIL tk_model act=%h exp=%h", {d, digit, dp}, {e_d, e_dig, e_dp});
            end
        end
        capture_frame(vals, dps, seen);
        checks++;
        if (vals !== 24'h000001 || seen !== 6'h3f) begin
            errors++;
            $display("FAIL tk_one_second vals=%h seen=%b exp=000001", vals, seen);
        end
        set_time(23, 59, 0);
        for (int i = 0; i < 240; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if ({d, digit, dp} !== {e_d, e_dig, e_dp}) begin
                errors++;
                $display("FAIL tk_rollover_model i=%0d act=%h exp=%h", i, {d, digit, dp}, {e_d, e_dig, e_dp});
            end
        end
        capture_frame(vals, dps, seen);
        checks++;
        if (vals !== 24'h000000 || seen !== 6'h3f) begin
            errors++;
            $display("FAIL tk_midnight vals=%h seen=%b exp=000000", vals, seen);
        end
    endtask

    task automatic test_simultaneous();
        logic [23:0] vals;
        logic [5:0]  dps;
        logic [5:0]  seen;
        mode24 = 1'b1;
        reset_dut();
        set_time(10, 10, 59 * TPS + TPS - 1);
        step(1'b1, 1'b1, 1'b0);
        capture_frame(vals, dps, seen);
        checks++;
        if (vals !== 24'h101100) begin
            errors++;
            $display("FAIL sim_min_vs_tick vals=%h exp=101100", vals);
        end
        reset_dut();
        set_time(23, 59, 59 * TPS + TPS - 1);
        step(1'b1, 1'b0, 1'b1);
        capture_frame(vals, dps, seen);
        checks++;
        if (vals !== 24'h000000) begin
            errors++;
            $display("FAIL sim_hour_vs_rollover vals=%h exp=000000", vals);
        end
    endtask

    task automatic test_12h();
        logic [23:0] vals;
        logic [5:0]  dps;
        logic [5:0]  seen;
        reset_dut();
        mode24 = 1'b0;
        capture_frame(vals, dps, seen);
        checks++;
        if (vals !== 24'h120000 || seen !== 6'h3f || dps[0] !== 1'b0) begin
            errors++;
            $display("FAIL h12_midnight vals=%h seen=%b pm=%b exp=120000/111111/0", vals, seen, dps[0]);
        end
        set_time(13, 0, 0);
        capture_frame(vals, dps, seen);
        checks++;
        if (seen !== 6'b011111 || vals[19:16] !== 4'd1 || dps[0] !== 1'b1) begin
            errors++;
            $display("FAIL h12_pm seen=%b hu=%0d pm=%b exp=011111/1/1", seen, vals[19:16], dps[0]);
        end
        mode24 = 1'b1;
        capture_frame(vals, dps, seen);
        checks++;
        if (vals !== 24'h130000 || seen !== 6'h3f || dps[0] !== 1'b0) begin
            errors++;
            $display("FAIL h24_13 vals=%h seen=%b pm=%b exp=130000/111111/0", vals, seen, dps[0]);
        end
    endtask

    task automatic test_colon();
        logic [23:0] vals;
        logic [5:0]  dps;
        logic [5:0]  seen;
        mode24 = 1'b1;
        reset_dut();
        for (int p = 0; p < TPS; p++) begin
            capture_frame(vals, dps, seen);
            checks++;
            if (dps[4] !== (p < TPS / 2)) begin
                errors++;
                $display("FAIL colon p=%0d dp=%b exp=%b", p, dps[4], (p < TPS / 2));
            end
            step(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        logic [23:0] vals;
        logic [5:0]  dps;
        logic [5:0]  seen;
        mode24 = 1'b1;
        reset_dut();
        set_time(12, 34, 56 * TPS);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (digit === 6'd0) begin
            errors++;
            $display("FAIL async_pre_active digit=%b exp=nonzero", digit);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (d !== 4'd0 || digit !== 6'd0 || dp !== 1'b0 || digit4 !== 4'd0) begin
            errors++;
            $display("FAIL async_clear d=%0d digit=%b dp=%b digit4=%b exp=0", d, digit, dp, digit4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        capture_frame(vals, dps, seen);
        checks++;
        if (vals !== 24'h000000 || seen !== 6'h3f) begin
            errors++;
            $display("FAIL async_time vals=%h seen=%b exp=000000", vals, seen);
        end
    endtask

    task automatic test_random();
        logic tk;
        logic mn;
        logic hr;
        mode24 = 1'b1;
        reset_dut();
        for (int i = 0; i < 4000; i++) begin
            tk = ($urandom_range(0, 1) == 1);
            mn = ($urandom_range(0, 24) == 0);
            hr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 63) == 0) mode24 = ~mode24;
            step(tk, mn, hr);
            checks++;
            if ({d, digit, dp} !== {e_d, e_dig, e_dp} || $countones(digit) > 1) begin
                errors++;
                $display("FAIL random i=%0d act d=%0d digit=%b dp=%b exp d=%0d digit=%b dp=%b",
                         i, d, digit, dp, e_d, e_dig, e_dp);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_timekeeping();
        test_simultaneous();
        test_12h();
        test_colon();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
